// File: rtl/signed_sat_pkg.sv
// Shared helpers for saturating signed arithmetic: clamp bounds and default counter width.
package signed_sat_pkg;

  localparam int unsigned CntWDefault = 8;

  // Largest positive W-bit two's-complement value: 0 followed by W-1 ones.
  function automatic logic [63:0] sat_max(input int unsigned w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative W-bit two's-complement value: 1 followed by W-1 zeros.
  function automatic logic [63:0] sat_min(input int unsigned w);
    return 64'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/signed_sat_clamp.sv
// Combinational clamp of a W+1-bit signed value into the W-bit signed range.
module signed_sat_clamp
  import signed_sat_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W:0]   val_i,
  output logic [W-1:0] clamp_o,
  output logic         sat_o
);

  localparam logic [W-1:0] MaxVal = W'(sat_max(W));
  localparam logic [W-1:0] MinVal = W'(sat_min(W));

  // The value fits in W bits exactly when its top two bits agree.
  always_comb begin
    clamp_o = val_i[W-1:0];
    sat_o   = 1'b0;
    case ({val_i[W], val_i[W-1]})
      2'b01: begin
        clamp_o = MaxVal;
        sat_o   = 1'b1;
      end
      2'b10: begin
        clamp_o = MinVal;
        sat_o   = 1'b1;
      end
      default: begin
        clamp_o = val_i[W-1:0];
        sat_o   = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// Two-stage valid/ready pipelined signed subtractor with saturation (res = a - b).
// Define SIGNED_SUB_SAT_CNT_EN to add the saturation event counter and its sat_cnt port.
module signed_sub_with_saturation_pipe
  import signed_sat_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = CntWDefault
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arg_vld,
  output logic             arg_rdy,
  input  logic [W-1:0]     a,
  input  logic [W-1:0]     b,
  output logic             res_vld,
  input  logic             res_rdy,
  output logic [W-1:0]     res,
  output logic             res_sat
`ifdef SIGNED_SUB_SAT_CNT_EN
  ,
  output logic [CNT_W-1:0] sat_cnt
`endif
);

  logic         s1_vld_q, s1_vld_d;
  logic [W:0]   s1_diff_q, s1_diff_d;
  logic         s2_vld_q, s2_vld_d;
  logic [W-1:0] res_q, res_d;
  logic         res_sat_q, res_sat_d;

  logic         rdy_s1, rdy_s2;
  logic [W:0]   diff;
  logic [W-1:0] clamp_val;
  logic         clamp_sat;

  assign rdy_s2  = ~s2_vld_q | res_rdy;
  assign rdy_s1  = ~s1_vld_q | rdy_s2;
  assign arg_rdy = rdy_s1;

  // Subtract at W+1 bits so -2^(W-1) as subtrahend needs no special handling.
  assign diff = {a[W-1], a} - {b[W-1], b};

  signed_sat_clamp #(
    .W(W)
  ) u_clamp (
    .val_i  (s1_diff_q),
    .clamp_o(clamp_val),
    .sat_o  (clamp_sat)
  );

  always_comb begin
    s1_vld_d  = s1_vld_q;
    s1_diff_d = s1_diff_q;
    s2_vld_d  = s2_vld_q;
    res_d     = res_q;
    res_sat_d = res_sat_q;
    if (rdy_s1) begin
      s1_vld_d = arg_vld;
      if (arg_vld) begin
        s1_diff_d = diff;
      end
    end
    if (rdy_s2) begin
      s2_vld_d = s1_vld_q;
      if (s1_vld_q) begin
        res_d     = clamp_val;
        res_sat_d = clamp_sat;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      s1_vld_q  <= 1'b0;
      s1_diff_q <= '0;
      s2_vld_q  <= 1'b0;
      res_q     <= '0;
      res_sat_q <= 1'b0;
    end else begin
      s1_vld_q  <= s1_vld_d;
      s1_diff_q <= s1_diff_d;
      s2_vld_q  <= s2_vld_d;
      res_q     <= res_d;
      res_sat_q <= res_sat_d;
    end
  end

  assign res_vld = s2_vld_q;
  assign res     = res_q;
  assign res_sat = res_sat_q;

`ifdef SIGNED_SUB_SAT_CNT_EN
  logic [CNT_W-1:0] sat_cnt_q, sat_cnt_d;

  // Counts saturating pairs as they enter stage 2; sticks at all-ones.
  always_comb begin
    sat_cnt_d = sat_cnt_q;
    if (rdy_s2 && s1_vld_q && clamp_sat && (sat_cnt_q != '1)) begin
      sat_cnt_d = sat_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      sat_cnt_q <= '0;
    end else begin
      sat_cnt_q <= sat_cnt_d;
    end
  end

  assign sat_cnt = sat_cnt_q;
`else
  logic unused_cnt_w;
  assign unused_cnt_w = ^CNT_W;
`endif

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Directed and table-driven bench for the saturating signed subtract pipe (W=4, CNT_W=2).
module tb_signed_sub_with_saturation_pipe;

  logic       clk;
  logic       rst;
  logic       arg_vld;
  logic       arg_rdy;
  logic [3:0] a;
  logic [3:0] b;
  logic       res_vld;
  logic       res_rdy;
  logic [3:0] res;
  logic       res_sat;
`ifdef SIGNED_SUB_SAT_CNT_EN
  logic [1:0] sat_cnt;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int n_out    = 0;
  logic [4:0] exp_q[$];

  signed_sub_with_saturation_pipe #(
    .W    (4),
    .CNT_W(2)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .arg_vld(arg_vld),
    .arg_rdy(arg_rdy),
    .a      (a),
    .b      (b),
    .res_vld(res_vld),
    .res_rdy(res_rdy),
    .res    (res),
    .res_sat(res_sat)
`ifdef SIGNED_SUB_SAT_CNT_EN
    ,
    .sat_cnt(sat_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] res;
    logic       sat;
  } vec_t;

  // Reference: integer difference clamped to [-8, 7]; returns {sat, res}.
  function automatic logic [4:0] model(input logic [3:0] x, input logic [3:0] y);
    int d;
    d = int'($signed(x)) - int'($signed(y));
    if (d > 7) return {1'b1, 4'b0111};
    if (d < -8) return {1'b1, 4'b1000};
    return {1'b0, d[3:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Samples the handshakes for the current cycle, runs the scoreboard, then waits one cycle.
  task automatic tick(output bit acc, output bit cons);
    acc  = arg_vld && arg_rdy && rst;
    cons = res_vld && res_rdy && rst;
    if (acc) exp_q.push_back(model(a, b));
    if (cons) begin
      n_out++;
      if (exp_q.size() == 0) begin
        chk("spurious_result", {27'd0, res_sat, res}, 32'hdead);
      end else begin
        chk("scoreboard", {27'd0, res_sat, res}, {27'd0, exp_q.pop_front()});
      end
    end
    @(negedge clk);
  endtask

  vec_t vecs[10];
  vec_t stall_p[3];
  logic [3:0] sat_a[5];
  logic [3:0] sat_b[5];
  logic [1:0] cnt_exp[5];

  initial begin
    bit acc, cons;
    int first_cyc, last_cyc, idx, got;
    logic [3:0] held_res;

    vecs[0] = '{4'd3,    4'd5,    4'b1110, 1'b0};
    vecs[1] = '{4'd7,    4'b1000, 4'b0111, 1'b1};
    vecs[2] = '{4'b1000, 4'd1,    4'b1000, 1'b1};
    vecs[3] = '{4'b1000, 4'b1000, 4'b0000, 1'b0};
    vecs[4] = '{4'b1111, 4'd7,    4'b1000, 1'b0};
    vecs[5] = '{4'd0,    4'b1000, 4'b0111, 1'b1};
    vecs[6] = '{4'b1000, 4'd7,    4'b1000, 1'b1};
    vecs[7] = '{4'd5,    4'd5,    4'b0000, 1'b0};
    vecs[8] = '{4'b1101, 4'd4,    4'b1001, 1'b0};
    vecs[9] = '{4'd6,    4'b1111, 4'b0111, 1'b0};

    stall_p[0] = '{4'd2,    4'b1101, 4'd5,    1'b0};
    stall_p[1] = '{4'b1011, 4'd4,    4'b1000, 1'b1};
    stall_p[2] = '{4'd6,    4'd7,    4'b1111, 1'b0};

    rst = 1'b0; arg_vld = 1'b0; a = '0; b = '0; res_rdy = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_res_vld", {31'd0, res_vld}, 32'd0);
    chk("reset_res", {28'd0, res}, 32'd0);
    chk("reset_res_sat", {31'd0, res_sat}, 32'd0);
    rst = 1'b1;
    #1;
    chk("reset_arg_rdy", {31'd0, arg_rdy}, 32'd1);
    @(negedge clk);

    // Single pairs with latency check against hand-computed values.
    for (int i = 0; i < 10; i++) begin
      arg_vld = 1'b1; a = vecs[i].a; b = vecs[i].b;
      #1;
      chk("vec_arg_rdy", {31'd0, arg_rdy}, 32'd1);
      tick(acc, cons);
      arg_vld = 1'b0;
      #1;
      chk("vec_lat1_vld", {31'd0, res_vld}, 32'd0);
      tick(acc, cons);
      #1;
      chk("vec_lat2_vld", {31'd0, res_vld}, 32'd1);
      chk("vec_res", {28'd0, res}, {28'd0, vecs[i].res});
      chk("vec_sat", {31'd0, res_sat}, {31'd0, vecs[i].sat});
      tick(acc, cons);
    end

    // Back-to-back random stream.
    n_out = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 0; c < 22; c++) begin
      arg_vld = (c < 16);
      a = 4'($urandom); b = 4'($urandom);
      #1;
      if (c < 16) chk("stream_arg_rdy", {31'd0, arg_rdy}, 32'd1);
      tick(acc, cons);
      if (cons) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
      end
    end
    chk("stream_count", n_out, 32'd16);
    chk("stream_first_cyc", first_cyc, 32'd2);
    chk("stream_last_cyc", last_cyc, 32'd17);

    // Backpressure: 3 pairs offered while downstream is stalled.
    res_rdy = 1'b0; idx = 0; n_out = 0;
    for (int c = 0; c < 6; c++) begin
      arg_vld = 1'b1; a = stall_p[idx].a; b = stall_p[idx].b;
      #1;
      chk("stall_arg_rdy", {31'd0, arg_rdy}, (c < 2) ? 32'd1 : 32'd0);
      if (c == 2) held_res = res;
      if (c >= 2) begin
        chk("stall_res_vld", {31'd0, res_vld}, 32'd1);
        chk("stall_res_hold", {28'd0, res}, {28'd0, stall_p[0].res});
        chk("stall_res_stable", {28'd0, res}, {28'd0, held_res});
      end
      tick(acc, cons);
      if (acc) idx++;
    end
    chk("stall_accepted", idx, 32'd2);
    res_rdy = 1'b1;
    #1;
    chk("release_arg_rdy", {31'd0, arg_rdy}, 32'd1);
    tick(acc, cons);
    if (acc) idx++;
    arg_vld = 1'b0;
    got = 0;
    while (n_out < 3 && got < 10) begin
      #1;
      tick(acc, cons);
      got++;
    end
    chk("stall_delivered", n_out, 32'd3);
    chk("stall_queue_empty", exp_q.size(), 32'd0);

    // Reset with two pairs in flight.
    res_rdy = 1'b0;
    for (int c = 0; c < 2; c++) begin
      arg_vld = 1'b1; a = 4'd1; b = 4'(c);
      #1;
      tick(acc, cons);
    end
    arg_vld = 1'b0; rst = 1'b0;
    #1;
    tick(acc, cons);
    rst = 1'b1;
    exp_q.delete();
    #1;
    chk("midrst_res_vld", {31'd0, res_vld}, 32'd0);
    chk("midrst_res", {28'd0, res}, 32'd0);
    chk("midrst_res_sat", {31'd0, res_sat}, 32'd0);
    chk("midrst_arg_rdy", {31'd0, arg_rdy}, 32'd1);
    res_rdy = 1'b1;
    n_out = 0;
    for (int c = 0; c < 4; c++) begin
      #1;
      tick(acc, cons);
    end
    chk("midrst_no_output", n_out, 32'd0);

`ifdef SIGNED_SUB_SAT_CNT_EN
    sat_a = '{4'd7, 4'b1000, 4'd6, 4'b1001, 4'd0};
    sat_b = '{4'b1000, 4'd1, 4'b1011, 4'd4, 4'b1000};
    cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    rst = 1'b0;
    #1;
    tick(acc, cons);
    rst = 1'b1;
    #1;
    chk("cnt_reset", {30'd0, sat_cnt}, 32'd0);
    for (int c = 0; c < 7; c++) begin
      arg_vld = (c < 5);
      if (c < 5) begin
        a = sat_a[c]; b = sat_b[c];
      end
      #1;
      if (c >= 2) chk("sat_cnt", {30'd0, sat_cnt}, {30'd0, cnt_exp[c-2]});
      tick(acc, cons);
    end
    arg_vld = 1'b0;
    repeat (3) begin
      #1;
      tick(acc, cons);
    end
`endif

    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
